// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: shadows the E/M/W control bits and derives
// stall/flush/freeze enables, E-stage forwarding selects and saturating event counters.
module hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic              uses_rs1_d,
    input  logic              uses_rs2_d,
    input  logic [REG_AW-1:0] rd_d,
    input  logic              reg_we_d,
    input  logic              memory_read_d,
    input  logic              memory_we_d,
    input  logic              take_e,
    input  logic              mem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              freeze,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic              r_e_valid, r_e_we, r_e_mr, r_e_mw;
    logic [REG_AW-1:0] r_e_rd, r_e_rs1, r_e_rs2;
    logic              r_m_valid, r_m_we, r_m_mr, r_m_mw;
    logic [REG_AW-1:0] r_m_rd;
    logic              r_w_valid, r_w_we, r_w_mr, r_w_mw;
    logic [REG_AW-1:0] r_w_rd;
    logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

    logic w_mem_busy, w_load_use, w_m_fwd_ok, w_w_fwd_ok, w_unused;

    // W keeps the memory bits for symmetry with the datapath; nothing downstream reads them.
    assign w_unused = &{1'b0, r_w_mr, r_w_mw};

    assign w_mem_busy = (r_m_mr | r_m_mw) & r_m_valid & ~mem_ready;
    assign w_load_use = r_e_valid & r_e_mr & (r_e_rd != '0) &
                        ((uses_rs1_d & (rs1_d == r_e_rd)) | (uses_rs2_d & (rs2_d == r_e_rd)));

    // A load result is not available in M yet, so M only forwards ALU results.
    assign w_m_fwd_ok = r_m_valid & r_m_we & ~r_m_mr & (r_m_rd != '0);
    assign w_w_fwd_ok = r_w_valid & r_w_we & (r_w_rd != '0);

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic m_ok, input logic [REG_AW-1:0] m_rd,
                                           input logic w_ok, input logic [REG_AW-1:0] w_rd);
        if (m_ok && (m_rd == rs))      return 2'b10;
        else if (w_ok && (w_rd == rs)) return 2'b01;
        else                           return 2'b00;
    endfunction

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        freeze  = 1'b0;
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (!rst) begin
            // A frozen E keeps take_e stable, so the branch flush simply waits for release.
            if (w_mem_busy) begin
                freeze  = 1'b1;
                stall_f = 1'b1;
                stall_d = 1'b1;
            end else if (take_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (w_load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
            fwd_a_e = fwd_sel(r_e_rs1, w_m_fwd_ok, r_m_rd, w_w_fwd_ok, r_w_rd);
            fwd_b_e = fwd_sel(r_e_rs2, w_m_fwd_ok, r_m_rd, w_w_fwd_ok, r_w_rd);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e_valid <= 1'b0; r_e_we <= 1'b0; r_e_mr <= 1'b0; r_e_mw <= 1'b0;
            r_e_rd    <= '0;   r_e_rs1 <= '0;  r_e_rs2 <= '0;
            r_m_valid <= 1'b0; r_m_we <= 1'b0; r_m_mr <= 1'b0; r_m_mw <= 1'b0; r_m_rd <= '0;
            r_w_valid <= 1'b0; r_w_we <= 1'b0; r_w_mr <= 1'b0; r_w_mw <= 1'b0; r_w_rd <= '0;
        end else if (!w_mem_busy) begin
            r_w_valid <= r_m_valid; r_w_we <= r_m_we; r_w_mr <= r_m_mr;
            r_w_mw    <= r_m_mw;    r_w_rd <= r_m_rd;
            r_m_valid <= r_e_valid; r_m_we <= r_e_we; r_m_mr <= r_e_mr;
            r_m_mw    <= r_e_mw;    r_m_rd <= r_e_rd;
            if (flush_e) begin
                r_e_valid <= 1'b0; r_e_we <= 1'b0; r_e_mr <= 1'b0; r_e_mw <= 1'b0;
                r_e_rd    <= '0;   r_e_rs1 <= '0;  r_e_rs2 <= '0;
            end else begin
                r_e_valid <= 1'b1;
                r_e_we    <= reg_we_d;
                r_e_mr    <= memory_read_d;
                r_e_mw    <= memory_we_d;
                r_e_rd    <= rd_d;
                r_e_rs1   <= uses_rs1_d ? rs1_d : '0;
                r_e_rs2   <= uses_rs2_d ? rs2_d : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_d && !freeze && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (flush_d && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control/forward values are queued as each
// cycle's stimulus is driven and compared against the DUT at the following falling edge.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       uses_rs1_d, uses_rs2_d, reg_we_d, memory_read_d, memory_we_d, take_e, mem_ready;
    logic       stall_f, stall_d, flush_d, flush_e, freeze;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic [3:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .uses_rs1_d(uses_rs1_d), .uses_rs2_d(uses_rs2_d),
        .rd_d(rd_d), .reg_we_d(reg_we_d), .memory_read_d(memory_read_d),
        .memory_we_d(memory_we_d), .take_e(take_e), .mem_ready(mem_ready),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .freeze(freeze), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ctl = {stall_f, stall_d, flush_d, flush_e, freeze}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] LU   = 5'b11010;
    localparam logic [4:0] BR   = 5'b00110;
    localparam logic [4:0] FRZ  = 5'b11001;

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        bit         chk_fwd;
    } exp_t;

    exp_t exp_q[$];

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic we, input logic mr,
                         input logic mw, input logic take, input logic ready);
        rs1_d = rs1; rs2_d = rs2; uses_rs1_d = u1; uses_rs2_d = u2; rd_d = rd;
        reg_we_d = we; memory_read_d = mr; memory_we_d = mw; take_e = take; mem_ready = ready;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                              input logic [1:0] fb, input bit chk_fwd);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.chk_fwd = chk_fwd;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = exp_q.pop_front();
        assert ({stall_f, stall_d, flush_d, flush_e, freeze} === e.ctl)
        else begin
            errors++;
            $error("FAIL %s ctl(sf,sd,fd,fe,frz) observed=%b expected=%b", e.tag,
                   {stall_f, stall_d, flush_d, flush_e, freeze}, e.ctl);
        end
        if (e.chk_fwd) begin
            checks++;
            assert ({fwd_a_e, fwd_b_e} === {e.fa, e.fb})
            else begin
                errors++;
                $error("FAIL %s fwd(a,b) observed=%b,%b expected=%b,%b", e.tag,
                       fwd_a_e, fwd_b_e, e.fa, e.fb);
            end
        end
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] es, input logic [3:0] ef);
        checks++;
        assert (stall_cnt === es)
        else begin
            errors++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, es);
        end
        checks++;
        assert (flush_cnt === ef)
        else begin
            errors++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, ef);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs are checked at the falling edge.
    task automatic step(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input bit chk_fwd);
        expect_out(tag, ctl, fa, fb, chk_fwd);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    // No valid load in M may target a register that a valid E instruction reads.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checks++;
            assert (!(dut.r_m_valid && dut.r_m_mr && dut.r_e_valid && (dut.r_m_rd != 5'd0) &&
                      ((dut.r_e_rs1 == dut.r_m_rd) || (dut.r_e_rs2 == dut.r_m_rd))))
            else begin
                errors++;
                $error("FAIL load_in_m_invariant observed=hazard rd_m=%0d expected=no hazard",
                       dut.r_m_rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=still running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        expect_out("reset_outputs", NONE, 2'b00, 2'b00, 1'b1);
        check_out();
        check_cnt("reset_counters", 4'd0, 4'd0);

        rst = 1'b0;
        // ALU forwarding: add x3; sub x4,x3,x3; nop; sub x10,x4,x4
        drive(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0, 1);   step("alu_c1", NONE, 2'b00, 2'b00, 1);
        drive(5'd3, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 1);   step("alu_c2", NONE, 2'b00, 2'b00, 1);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);   step("alu_back2back", NONE, 2'b10, 2'b10, 1);
        drive(5'd4, 5'd4, 1, 1, 5'd10, 1, 0, 0, 0, 1);  step("alu_nop_in_e", NONE, 2'b00, 2'b00, 1);
        // Double hazard: addi x7; addi x7; add x11,x7,x7
        drive(5'd1, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 1);   step("alu_one_nop", NONE, 2'b01, 2'b01, 1);
        drive(5'd2, 5'd0, 1, 0, 5'd7, 1, 0, 0, 0, 1);   step("dbl_c1", NONE, 2'b00, 2'b00, 1);
        drive(5'd7, 5'd7, 1, 1, 5'd11, 1, 0, 0, 0, 1);  step("dbl_c2", NONE, 2'b00, 2'b00, 1);
        // x0 destinations: addi x0; lw x0; add x12,x0,x0
        drive(5'd1, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, 1);   step("double_hazard", NONE, 2'b10, 2'b10, 1);
        drive(5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0, 0, 1);   step("x0_c1", NONE, 2'b00, 2'b00, 1);
        drive(5'd0, 5'd0, 1, 1, 5'd12, 1, 0, 0, 0, 1);  step("x0_no_stall", NONE, 2'b00, 2'b00, 1);
        // Load-use: lw x5; add x6,x5,x1
        drive(5'd1, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, 1);   step("x0_no_fwd", NONE, 2'b00, 2'b00, 1);
        drive(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 1);   step("load_use", LU, 2'b00, 2'b00, 1);
        drive(5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 0, 1);   step("load_in_m", NONE, 2'b00, 2'b00, 1);
        check_cnt("cnt_after_load_use", 4'd1, 4'd0);
        // Taken branch coinciding with a load-use: lw x8 then add x9,x8,x8 with take_e
        drive(5'd1, 5'd0, 1, 0, 5'd8, 1, 1, 0, 0, 1);   step("load_fwd_w", NONE, 2'b01, 2'b00, 1);
        drive(5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 1, 1);   step("branch_over_lu", BR, 2'b00, 2'b00, 1);
        drive(5'd8, 5'd8, 1, 1, 5'd9, 1, 0, 0, 0, 1);   step("branch_e_bubble", NONE, 2'b00, 2'b00, 1);
        check_cnt("cnt_after_branch", 4'd1, 4'd1);
        // Freeze: sw reaches M with mem_ready low while lw x13 in E sees take_e and a load-use
        drive(5'd1, 5'd2, 1, 1, 5'd0, 0, 0, 1, 0, 1);   step("store_c1", NONE, 2'b01, 2'b01, 1);
        drive(5'd9, 5'd0, 1, 0, 5'd13, 1, 1, 0, 0, 1);  step("store_c2", NONE, 2'b00, 2'b00, 1);
        for (int k = 0; k < 3; k++) begin
            drive(5'd13, 5'd9, 1, 1, 5'd14, 1, 0, 0, 1, 0);
            step($sformatf("freeze_%0d", k), FRZ, 2'b01, 2'b00, 1);
        end
        check_cnt("cnt_during_freeze", 4'd1, 4'd1);
        drive(5'd13, 5'd9, 1, 1, 5'd14, 1, 0, 0, 1, 1); step("freeze_release", BR, 2'b01, 2'b00, 1);

        // Refreeze on the load now in M, then reset asynchronously between edges
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);
        expect_out("refreeze", FRZ, 2'b00, 2'b00, 1);
        @(negedge clk);
        check_out();
        check_cnt("cnt_before_reset", 4'd1, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        expect_out("reset_mid_freeze", NONE, 2'b00, 2'b00, 1);
        check_out();
        check_cnt("cnt_reset_mid_freeze", 4'd0, 4'd0);
        #1;
        drive(5'd1, 5'd2, 1, 1, 5'd15, 1, 0, 0, 0, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(5'd15, 5'd15, 1, 1, 5'd16, 1, 0, 0, 0, 1); step("post_reset_c1", NONE, 2'b00, 2'b00, 1);
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 1);    step("post_reset_fwd", NONE, 2'b10, 2'b10, 1);

        // Saturation: 20 load-use stalls into a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive(5'd1, 5'd0, 1, 0, 5'd20, 1, 1, 0, 0, 1);  step("sat_lw", NONE, 2'b00, 2'b00, 0);
            drive(5'd20, 5'd0, 1, 0, 5'd21, 1, 0, 0, 0, 1); step("sat_stall", LU, 2'b00, 2'b00, 0);
            drive(5'd20, 5'd0, 1, 0, 5'd21, 1, 0, 0, 0, 1); step("sat_held", NONE, 2'b00, 2'b00, 0);
            if (i == 14) check_cnt("cnt_reach_max", 4'd15, 4'd0);
        end
        check_cnt("cnt_saturated", 4'd15, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core (F, D, E, M, W). It keeps a shadow pipeline of the destination-register and control bits that the decode controller produces, and advances it in lockstep with the datapath registers. From that state it generates stall, flush and freeze enables for the pipeline registers, plus forwarding selects for the E-stage ALU operands. It also holds saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- REG_AW, 5, register address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rs1_d  input  REG_AW  D-stage source register 1.
- rs2_d  input  REG_AW  D-stage source register 2.
- uses_rs1_d  input  1  the D-stage instruction reads rs1.
- uses_rs2_d  input  1  the D-stage instruction reads rs2.
- rd_d  input  REG_AW  D-stage destination register.
- reg_we_d  input  1  D-stage instruction writes the register file.
- memory_read_d  input  1  D-stage instruction is a load.
- memory_we_d  input  1  D-stage instruction is a store.
- take_e  input  1  branch or jump in E is resolved taken this cycle.
- mem_ready  input  1  data memory completes the M-stage access this cycle.
- stall_f  output  1  hold the PC.
- stall_d  output  1  hold the F/D register.
- flush_d  output  1  clear the F/D register to a bubble.
- flush_e  output  1  load a bubble into the D/E register.
- freeze  output  1  hold the D/E, E/M and M/W registers.
- fwd_a_e  output  2  ALU operand A source: 00 register file, 01 W result, 10 M result.
- fwd_b_e  output  2  ALU operand B source, same encoding as fwd_a_e.
- stall_cnt  output  CNT_W  cycles with stall_d=1.
- flush_cnt  output  CNT_W  cycles with flush_d=1.

## Operation
- Shadow stages E, M and W each hold: valid, rd, reg_we, mem_read, mem_we. Stage E also holds rs1 and rs2 (operands not used are stored as 0).
- A bubble is: all bits 0 and rd=0.
- mem_busy = (mem_read_m | mem_we_m) & valid_m & ~mem_ready.
- freeze = mem_busy.
- load_use = valid_e & mem_read_e & rd_e!=0 & ((uses_rs1_d & rs1_d==rd_e) | (uses_rs2_d & rs2_d==rd_e)).
- Priority, highest first:
  - freeze=1: stall_f=stall_d=1 and flush_d=flush_e=0. take_e is ignored, because E is frozen and take_e stays stable. The flush takes effect in the first cycle with freeze=0.
  - take_e=1: flush_d=flush_e=1 and stall_f=stall_d=0. A load_use in the same cycle is discarded.
  - load_use=1: stall_f=stall_d=1, flush_e=1, flush_d=0. This lasts exactly one cycle, because the load then moves to M.
  - Otherwise all of these outputs are 0.
- Shadow update on each clock edge:
  - When freeze=0: W<=M, M<=E, and E<=bubble if flush_e, else E<=D fields with valid=1.
  - When freeze=1: all stages hold their values.
- Forwarding, evaluated for rs1_e (fwd_a_e) and rs2_e (fwd_b_e):
  - 10 if valid_m & reg_we_m & ~mem_read_m & rd_m!=0 & rd_m==rs_e.
  - Else 01 if valid_w & reg_we_w & rd_w!=0 & rd_w==rs_e.
  - Else 00.
  - M takes precedence over W.
- Invariant: no valid load in M has rd matching a nonzero rs of a valid E instruction. Load-use stalling guarantees this; the bench checks it as an assertion.
- Counters:
  - stall_cnt increments on each clock where stall_d=1 and freeze=0.
  - flush_cnt increments on each clock where flush_d=1.
  - Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- All control and forwarding outputs are combinational from the current inputs and shadow state, valid within the same cycle. No output is registered.
- Load-use penalty is 1 cycle. Taken branch penalty is 2 instructions (D and E are flushed). Freeze lasts for as many cycles as mem_ready is low.
- Reset:
  - Asserting rst immediately clears all shadow stages to bubbles and both counters to 0. This applies even mid-stall or mid-freeze.
  - While rst=1, all outputs are 0 and fwd selects are 00.
  - The first edge after rst falls loads E from D normally.
- rd=0 never causes a stall or a forward.
- Simultaneous freeze, take_e and load_use resolve as freeze only. After release, take_e is evaluated again with the D inputs of that cycle.

## Test plan
- Load-use: lw x5 in E and add x6,x5,x1 in D. Required: stall_f=stall_d=flush_e=1 for one cycle. The next cycle has the load in M, stall=0, and fwd_a_e=00. The cycle after has fwd_a_e=01. stall_cnt=1.
- ALU forwarding: add x3 then sub x4,x3,x3 back to back. Required: fwd_a_e=fwd_b_e=10 when sub is in E. With one nop between them, both are 01.
- Double hazard: writes to x7 in both M and W, and E reads x7. Required: fwd=10.
- Taken branch: take_e=1 with load_use also true. Required: flush_d=flush_e=1, stall=0, flush_cnt=1, and E holds a bubble next cycle.
- Freeze: store in M and mem_ready=0 for 3 cycles while take_e=1. Required: freeze=stall_f=stall_d=1 and flush=0 for 3 cycles, with shadow state unchanged. Then flush_d=flush_e=1 in the release cycle.
- Async reset asserted mid-freeze, between clock edges. Required: all outputs 0 immediately and counters 0. x0 destination: an instruction writing x0 causes no stall and no forward. Counter saturation: force CNT_W=4 and run 20 stalls; stall_cnt must hold at 15.
